// File: rtl/dnn_accel_pkg.sv
// Shared types and constants for the word-copy DMA master.
package dnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bytes per bus word for the default 32-bit data path.
  localparam int AVM_BYTES = 4;

endpackage

// File: rtl/dnn_accel_word_copy_master_if.sv
// Avalon-MM master bundle between the copy engine and the SRAM slaves.
interface dnn_accel_word_copy_master_if
  import dnn_accel_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8 * AVM_BYTES
);

  logic [ADDR_W-1:0]   master_address;
  logic                master_read;
  logic                master_write;
  logic [DATA_W/8-1:0] master_byteenable;
  logic [DATA_W-1:0]   master_writedata;
  logic                master_waitrequest;
  logic [DATA_W-1:0]   master_readdata;
  logic                master_readdatavalid;

  modport master (
    output master_address, master_read, master_write,
           master_byteenable, master_writedata,
    input  master_waitrequest, master_readdata, master_readdatavalid
  );

  modport slave (
    input  master_address, master_read, master_write,
           master_byteenable, master_writedata,
    output master_waitrequest, master_readdata, master_readdatavalid
  );

endinterface

// File: rtl/dnn_accel_sync_fifo.sv
// Read-data buffer between the read and write sides of the copy engine.
// DEPTH must be a power of two so the pointers wrap naturally.
module dnn_accel_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage array: written on push, no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/dnn_accel_word_copy_master.sv
// Word-copy DMA master: streams reads from a source range into a FIFO and
// drains it as writes to a destination range over one Avalon-MM port.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | waiting for start, bus quiet
//   ST_RUN  | issuing reads/writes until the last write is accepted
//   ST_DONE | single cycle, done pulse, back to idle
module dnn_accel_word_copy_master
  import dnn_accel_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8 * AVM_BYTES,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             src_addr,
  input  logic [ADDR_W-1:0]             dst_addr,
  input  logic [LEN_W-1:0]              num_words,
  output logic                          busy,
  output logic                          done,
  dnn_accel_word_copy_master_if.master  avm
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [LEN_W-1:0]   rd_left, wr_left;
  logic [CNT_W-1:0]   in_flight;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_dout;
  logic               pend_rd, pend_wr;
  logic               sel_rd, sel_wr;
  logic               acc_rd, acc_wr;
  logic               rd_push;
  logic               credit_ok;

  // Reads may only be launched while buffered plus outstanding words fit the FIFO.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < (CNT_W + 1)'(FIFO_DEPTH);

  assign acc_rd  = sel_rd && !avm.master_waitrequest;
  assign acc_wr  = sel_wr && !avm.master_waitrequest;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign rd_push = avm.master_readdatavalid && (in_flight != '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and command arbitration; a stalled command keeps its type
  // and, because address/data only move on accept, its payload too.
  always_comb begin
    state_nxt = state;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_words == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (pend_wr)                          sel_wr = 1'b1;
        else if (pend_rd)                     sel_rd = 1'b1;
        else if (!fifo_empty)                 sel_wr = 1'b1;
        else if (rd_left != '0 && credit_ok)  sel_rd = 1'b1;
        if (sel_wr && !avm.master_waitrequest && wr_left == LEN_W'(1))
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Remember which command is stalled so arbitration cannot switch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
    end else begin
      pend_rd <= sel_rd && avm.master_waitrequest;
      pend_wr <= sel_wr && avm.master_waitrequest;
    end
  end

  // Address and remaining-word counters, loaded on start and stepped on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      wr_addr <= '0;
      rd_left <= '0;
      wr_left <= '0;
    end else if (state == ST_IDLE && start) begin
      rd_addr <= src_addr;
      wr_addr <= dst_addr;
      rd_left <= num_words;
      wr_left <= num_words;
    end else begin
      if (acc_rd) begin
        rd_addr <= rd_addr + ADDR_STEP;
        rd_left <= rd_left - LEN_W'(1);
      end
      if (acc_wr) begin
        wr_addr <= wr_addr + ADDR_STEP;
        wr_left <= wr_left - LEN_W'(1);
      end
    end
  end

  // Outstanding read count: up on read accept, down on each valid return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({acc_rd, rd_push})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  dnn_accel_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_push),
    .pop   (acc_wr),
    .din   (avm.master_readdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign avm.master_read       = sel_rd;
  assign avm.master_write      = sel_wr;
  assign avm.master_address    = sel_wr ? wr_addr : (sel_rd ? rd_addr : '0);
  assign avm.master_byteenable = (sel_rd || sel_wr) ? '1 : '0;
  assign avm.master_writedata  = sel_wr ? fifo_dout : '0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_dnn_accel_word_copy_master.sv
// Bench for the word-copy master: a negedge slave/monitor process answers
// bus commands and checks them against expectation queues filled by the
// stimulus process when each copy is launched.
module tb_dnn_accel_word_copy_master;
  import dnn_accel_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy, done;

  dnn_accel_word_copy_master_if avm ();

  dnn_accel_word_copy_master dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .avm       (avm)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  rsp_t        rsp_q[$];
  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];

  int pass_cnt = 0, total_cnt = 0;
  int cfg_wait = 0, cfg_lat = 1, cyc = 0, stall_cnt = 0;
  int done_cnt = 0, cmd_cnt = 0, rd_acc = 0, wr_acc = 0;
  bit          stalled = 0;
  logic [1:0]  held_type;
  logic [31:0] held_addr, held_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Slave model and monitor: decides waitrequest, returns read data after
  // cfg_lat cycles, and compares every accepted command with the queues.
  initial begin
    wr_t e;
    avm.master_waitrequest   = 1'b0;
    avm.master_readdatavalid = 1'b0;
    avm.master_readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      avm.master_readdatavalid = 1'b0;
      avm.master_readdata      = '0;
      if (rsp_q.size() > 0) begin
        if (rsp_q[0].due == cyc) begin
          avm.master_readdatavalid = 1'b1;
          avm.master_readdata      = rsp_q[0].data;
          void'(rsp_q.pop_front());
        end
      end
      if (reset) begin
        avm.master_waitrequest = 1'b0;
        stall_cnt = 0;
        stalled   = 0;
        continue;
      end
      if (done) done_cnt++;
      if (avm.master_read || avm.master_write) begin
        cmd_cnt++;
        chk("one_cmd", {avm.master_read, avm.master_write} != 2'b11, 1);
        if (stalled) begin
          chk("hold_type", {avm.master_read, avm.master_write}, held_type);
          chk("hold_addr", avm.master_address, held_addr);
          chk("hold_data", avm.master_writedata, held_data);
        end
        if (stall_cnt < cfg_wait) begin
          avm.master_waitrequest = 1'b1;
          stall_cnt++;
          stalled   = 1;
          held_type = {avm.master_read, avm.master_write};
          held_addr = avm.master_address;
          held_data = avm.master_writedata;
        end else begin
          avm.master_waitrequest = 1'b0;
          stall_cnt = 0;
          stalled   = 0;
          chk("byteenable", avm.master_byteenable, 4'hF);
          if (avm.master_read) begin
            if (exp_rd_q.size() == 0) chk("unexpected_read", avm.master_address, 64'hDEAD);
            else chk("rd_addr", avm.master_address, exp_rd_q.pop_front());
            chk("credit", (rd_acc - wr_acc) < 8, 1);
            rd_acc++;
            rsp_q.push_back('{cyc + cfg_lat, src_word(avm.master_address)});
          end else begin
            if (exp_wr_q.size() == 0) chk("unexpected_write", avm.master_address, 64'hDEAD);
            else begin
              e = exp_wr_q.pop_front();
              chk("wr_addr", avm.master_address, e.addr);
              chk("wr_data", avm.master_writedata, e.data);
            end
            wr_acc++;
          end
        end
      end else begin
        avm.master_waitrequest = 1'b0;
        if (stalled) chk("cmd_dropped_while_stalled", 0, 1);
        stall_cnt = 0;
        stalled   = 0;
      end
    end
  end

  task automatic reset_sb();
    exp_rd_q.delete();
    exp_wr_q.delete();
    done_cnt = 0;
    cmd_cnt  = 0;
    rd_acc   = 0;
    wr_acc   = 0;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n,
                        input int wt, input int lat);
    reset_sb();
    cfg_wait = wt;
    cfg_lat  = lat;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(s + 32'(4 * i));
      exp_wr_q.push_back('{d + 32'(4 * i), src_word(s + 32'(4 * i))});
    end
    @(negedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; num_words = 16'(n);
    @(negedge clk); #1;
    start = 1'b0; src_addr = '0; dst_addr = '0; num_words = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({name, "_timeout"}, done_cnt != 0, 1);
    repeat (3) begin @(negedge clk); #1; end
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_writes_left"}, exp_wr_q.size(), 0);
    chk({name, "_reads_left"}, exp_rd_q.size(), 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", avm.master_read, 0);
    chk("rst_write", avm.master_write, 0);
    chk("rst_addr", avm.master_address, 0);
    chk("rst_be", avm.master_byteenable, 0);
    #1 reset = 1'b0;

    // 1: basic copy, zero wait, 1-cycle latency; first read right after start
    launch(32'h0000_0000, 32'h0000_4000, 4, 0, 1);
    chk("t1_first_read", avm.master_read, 1);
    chk("t1_first_addr", avm.master_address, 32'h0000_0000);
    chk("t1_busy", busy, 1);
    wait_done("t1", 200);

    // 2: zero-length copy: one DONE cycle, no bus traffic
    launch(32'h0000_1000, 32'h0000_5000, 0, 0, 1);
    chk("t2_busy_done_cycle", busy, 1);
    chk("t2_done_pulse", done, 1);
    @(negedge clk); #1;
    chk("t2_busy_after", busy, 0);
    chk("t2_done_after", done, 0);
    repeat (3) begin @(negedge clk); #1; end
    chk("t2_no_cmds", cmd_cnt, 0);
    chk("t2_done_once", done_cnt, 1);

    // 3: three stall cycles on every command
    launch(32'h0000_0100, 32'h0000_4100, 4, 3, 2);
    wait_done("t3", 400);

    // 4: long latency exercises the credit limit; a start while busy is ignored
    launch(32'h0000_0200, 32'h0000_4200, 20, 0, 12);
    repeat (4) begin @(negedge clk); #1; end
    start = 1'b1; src_addr = 32'h0000_9000; dst_addr = 32'h0000_A000; num_words = 16'd5;
    @(negedge clk); #1;
    start = 1'b0; src_addr = '0; dst_addr = '0; num_words = '0;
    wait_done("t4", 1000);

    // 5: source range wraps through zero
    launch(32'hFFFF_FFF8, 32'h0000_0100, 4, 0, 1);
    wait_done("t5", 200);

    // 6: reset mid-copy, drain stale returns, then a clean 2-word copy
    launch(32'h0000_2000, 32'h0000_6000, 8, 0, 6);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_read", avm.master_read, 0);
    chk("t6_rst_write", avm.master_write, 0);
    chk("t6_rst_addr", avm.master_address, 0);
    chk("t6_rst_be", avm.master_byteenable, 0);
    chk("t6_rst_wdata", avm.master_writedata, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    begin
      int k = 0;
      while (rsp_q.size() != 0 && k < 50) begin
        @(negedge clk); #1;
        k++;
      end
      chk("t6_stale_drained", rsp_q.size(), 0);
    end
    @(negedge clk); #1;
    chk("t6_no_done_after_abort", done_cnt, 0);
    chk("t6_idle_after_abort", busy, 0);
    launch(32'h0000_3000, 32'h0000_7000, 2, 0, 1);
    wait_done("t6", 200);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
